// File: rtl/bram_stream_ctrl.sv
// Single-port BRAM controller: burst reader (word -> narrow beats) and wide-word writer,
// arbitrated by an IDLE/RD/WR FSM. Define BRAM_CTRL_MSB_FIRST_EN for MSB-slice-first order.
module bram_stream_ctrl #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned BRAM_DW = 32,
    parameter int unsigned WR_DW   = 512,
    parameter int unsigned RD_DW   = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_start_i,
    input  logic [ADDR_W-1:0]    rd_base_i,
    input  logic [ADDR_W-1:0]    rd_len_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [RD_DW-1:0]     rd_data_o,
    output logic                 rd_last_o,
    output logic                 rd_busy_o,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [WR_DW-1:0]     wr_data_i,
    input  logic [ADDR_W-1:0]    wr_base_i,
    output logic                 wr_done_o,
    output logic [ADDR_W-1:0]    bram_addr_o,
    output logic                 bram_en_o,
    output logic [BRAM_DW/8-1:0] bram_we_o,
    output logic [BRAM_DW-1:0]   bram_din_o,
    input  logic [BRAM_DW-1:0]   bram_dout_i
);

`ifdef BRAM_CTRL_MSB_FIRST_EN
    localparam bit MsbFirst = 1'b1;
`else
    localparam bit MsbFirst = 1'b0;
`endif

    localparam int unsigned BEATS  = BRAM_DW / RD_DW;
    localparam int unsigned NWR    = WR_DW / BRAM_DW;
    localparam int unsigned DEPTH  = RD_LAT + 1;
    localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WIDX_W = (NWR > 1) ? $clog2(NWR) : 1;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1) + 1;

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e                state_q;
    logic                  bram_en_q;
    logic [BRAM_DW/8-1:0]  bram_we_q;
    logic [ADDR_W-1:0]     bram_addr_q;
    logic [BRAM_DW-1:0]    bram_din_q;
    logic                  wr_done_q;

    // Reader state: fetch side, latency pipe, word FIFO and unpack register.
    logic [ADDR_W-1:0]     fetch_addr_q;
    logic [ADDR_W-1:0]     fetch_left_q;
    logic [ADDR_W-1:0]     pop_left_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [RD_LAT-1:0]     lat_sr_q;
    logic [BRAM_DW-1:0]    fifo_q [DEPTH];
    logic [PTR_W-1:0]      fifo_wp_q;
    logic [PTR_W-1:0]      fifo_rp_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic [BRAM_DW-1:0]    out_word_q;
    logic                  out_vld_q;
    logic                  out_last_word_q;
    logic [BIDX_W-1:0]     beat_idx_q;

    // Writer state.
    logic [WR_DW-1:0]      wr_sr_q;
    logic [WIDX_W-1:0]     wr_idx_q;

    logic rd_issue, capture, last_beat, beat_acc, out_free, pop, issue;

    function automatic logic [BRAM_DW-1:0] wr_head(input logic [WR_DW-1:0] w);
        return MsbFirst ? w[WR_DW-1 -: BRAM_DW] : w[BRAM_DW-1:0];
    endfunction

    function automatic logic [WR_DW-1:0] wr_next(input logic [WR_DW-1:0] w);
        return MsbFirst ? (w << BRAM_DW) : (w >> BRAM_DW);
    endfunction

    assign rd_issue  = bram_en_q && !(|bram_we_q);
    assign capture   = lat_sr_q[RD_LAT-1];
    assign last_beat = (beat_idx_q == BIDX_W'(BEATS - 1));
    assign beat_acc  = out_vld_q && rd_ready_i;
    assign out_free  = !out_vld_q || (beat_acc && last_beat);
    assign pop       = (state_q == StRd) && out_free && (fifo_cnt_q != '0);
    // cnt_q counts FIFO words plus reads in flight; a word leaving for the unpack
    // register frees its credit in the same cycle.
    assign issue     = (state_q == StRd) && (fetch_left_q != '0) &&
                       ((cnt_q - CNT_W'(pop)) < CNT_W'(DEPTH));

    assign rd_valid_o  = out_vld_q;
    assign rd_data_o   = MsbFirst ? out_word_q[BRAM_DW-1 -: RD_DW] : out_word_q[RD_DW-1:0];
    assign rd_last_o   = out_vld_q && out_last_word_q && last_beat;
    assign rd_busy_o   = (state_q == StRd);
    assign wr_ready_o  = (state_q == StIdle) && !rd_start_i && !rst_i;
    assign wr_done_o   = wr_done_q;
    assign bram_addr_o = bram_addr_q;
    assign bram_en_o   = bram_en_q;
    assign bram_we_o   = bram_we_q;
    assign bram_din_o  = bram_din_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            bram_en_q       <= 1'b0;
            bram_we_q       <= '0;
            bram_addr_q     <= '0;
            bram_din_q      <= '0;
            wr_done_q       <= 1'b0;
            fetch_addr_q    <= '0;
            fetch_left_q    <= '0;
            pop_left_q      <= '0;
            cnt_q           <= '0;
            lat_sr_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
            fifo_wp_q       <= '0;
            fifo_rp_q       <= '0;
            fifo_cnt_q      <= '0;
            out_word_q      <= '0;
            out_vld_q       <= 1'b0;
            out_last_word_q <= 1'b0;
            beat_idx_q      <= '0;
            wr_sr_q         <= '0;
            wr_idx_q        <= '0;
        end else begin
            wr_done_q <= 1'b0;
            lat_sr_q  <= RD_LAT'({lat_sr_q, rd_issue});

            if (capture) begin
                fifo_q[fifo_wp_q] <= bram_dout_i;
                fifo_wp_q <= (fifo_wp_q == PTR_W'(DEPTH - 1)) ? '0 : fifo_wp_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_rp_q <= (fifo_rp_q == PTR_W'(DEPTH - 1)) ? '0 : fifo_rp_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(capture) - CNT_W'(pop);

            unique case (state_q)
                StIdle: begin
                    bram_en_q <= 1'b0;
                    bram_we_q <= '0;
                    if (rd_start_i) begin
                        state_q    <= StRd;
                        pop_left_q <= rd_len_i;
                        if (rd_len_i != '0) begin
                            // First fetch goes out with the state change.
                            bram_en_q    <= 1'b1;
                            bram_addr_q  <= rd_base_i;
                            fetch_addr_q <= rd_base_i + ADDR_W'(1);
                            fetch_left_q <= rd_len_i - ADDR_W'(1);
                            cnt_q        <= CNT_W'(1);
                        end else begin
                            fetch_left_q <= '0;
                            cnt_q        <= '0;
                        end
                    end else if (wr_valid_i) begin
                        state_q     <= StWr;
                        bram_en_q   <= 1'b1;
                        bram_we_q   <= '1;
                        bram_addr_q <= wr_base_i;
                        bram_din_q  <= wr_head(wr_data_i);
                        wr_sr_q     <= wr_next(wr_data_i);
                        wr_idx_q    <= '0;
                    end
                end

                StRd: begin
                    bram_en_q <= issue;
                    bram_we_q <= '0;
                    if (issue) begin
                        bram_addr_q  <= fetch_addr_q;
                        fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
                        fetch_left_q <= fetch_left_q - ADDR_W'(1);
                    end
                    cnt_q <= cnt_q + CNT_W'(issue) - CNT_W'(pop);

                    if (pop) begin
                        out_word_q      <= fifo_q[fifo_rp_q];
                        out_vld_q       <= 1'b1;
                        beat_idx_q      <= '0;
                        out_last_word_q <= (pop_left_q == ADDR_W'(1));
                        pop_left_q      <= pop_left_q - ADDR_W'(1);
                    end else if (beat_acc) begin
                        if (last_beat) begin
                            out_vld_q <= 1'b0;
                        end else begin
                            beat_idx_q <= beat_idx_q + BIDX_W'(1);
                            out_word_q <= MsbFirst ? (out_word_q << RD_DW) : (out_word_q >> RD_DW);
                        end
                    end

                    // Second term only fires for a zero-length burst.
                    if ((beat_acc && rd_last_o) || (pop_left_q == '0 && !out_vld_q)) begin
                        state_q <= StIdle;
                    end
                end

                StWr: begin
                    if (wr_idx_q == WIDX_W'(NWR - 1)) begin
                        state_q   <= StIdle;
                        bram_en_q <= 1'b0;
                        bram_we_q <= '0;
                        wr_done_q <= 1'b1;
                    end else begin
                        bram_addr_q <= bram_addr_q + ADDR_W'(1);
                        bram_din_q  <= wr_head(wr_sr_q);
                        wr_sr_q     <= wr_next(wr_sr_q);
                        wr_idx_q    <= wr_idx_q + WIDX_W'(1);
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
